rv32_decode_stage: RTL and testbench
====================================

// Module: rv32_decode_stage
// PURPOSE
//  Parametrised RV32I(+M) decode stage with valid/ready handshake, flush and illegal-instruction detection.
//  Sits between fetch and execute: registers inst/pc plus decoded ALU-op, opcode-class, imm and reg-addr fields
//  into one pipeline slot. Optionally decodes the M extension. Provides combinational rs1/rs2 addresses so the
//  register-file read is aligned with the registered outputs.
// PARAMETERS
//  PC_WIDTH  32  width of pc_in/pc_out
//  ENABLE_M  0   1: decode MUL/DIV/REM (funct7=0000001); 0: such encodings are illegal
//  ALU_W     (ENABLE_M?22:14)  derived localparam, width of alu_op
// PORTS
//  clk        in   1         clock
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         fetch presents inst/pc
//  in_ready   out  1         stage can accept this cycle
//  inst       in   32        instruction word
//  pc_in      in   PC_WIDTH  instruction address
//  flush      in   1         discard slot contents and incoming beat
//  rs1_addr_d out  5         inst[19:15], combinational
//  rs2_addr_d out  5         inst[24:20], combinational
//  out_valid  out  1         slot holds a decoded instruction
//  out_ready  in   1         execute consumes slot
//  pc_out     out  PC_WIDTH  registered pc
//  rs1_addr   out  5         registered rs1; rs2_addr out 5 registered rs2; rd_addr out 5 registered rd
//  funct3     out  3         registered inst[14:12]
//  imm        out  32        registered sign-extended immediate
//  alu_op     out  ALU_W     one-hot: 0 add,1 sub,2 slt,3 sltu,4 xor,5 or,6 and,7 sll,8 srl,9 sra,10 eq,
//                            11 neq,12 ge,13 geu,[M] 14 mul,15 mulh,16 mulhsu,17 mulhu,18 div,19 divu,20 rem,21 remu
//  opcode_vec out  11        one-hot: 0 rtype,1 itype,2 load,3 store,4 branch,5 jal,6 jalr,7 lui,8 auipc,9 system,10 fence
//  illegal    out  1         registered illegal-instruction flag
// BEHAVIOUR
//  Reset: out_valid=0, every registered output 0; in_ready=1 after reset.
//  in_ready = !out_valid | out_ready (combinational; no dependence on in_valid).
//  load = in_valid & in_ready & !flush. Latency 1: inst accepted at edge N visible on outputs after edge N.
//  Edge update priority: flush -> out_valid<=0, data regs unchanged; else load -> out_valid<=1, all data regs
//   take decoded values; else if out_ready -> out_valid<=0; else hold (all outputs stable while out_valid & !out_ready).
//  Simultaneous consume+accept: back-to-back, out_valid stays 1, no bubble.
//  Decode (combinational, captured on load):
//   R/I-type: funct3 000 -> add (R with inst[30]=1 -> sub); 010 slt; 011 sltu; 100 xor; 110 or; 111 and; 001 sll;
//    101 -> srl (inst[30]=0) / sra (inst[30]=1). Branch: 000 eq,001 neq,100 slt,101 ge,110 sltu,111 geu.
//   M (ENABLE_M=1, R-type, funct7=0000001): funct3 000..111 -> bits 14..21 in order; add/sub bits 0.
//   All other legal opcodes -> add.
//  Imm: I/LOAD/JALR {20{i31},i[31:20]}; STORE {20{i31},i[31:25],i[11:7]}; BRANCH {19{i31},i31,i7,i[30:25],i[11:8],0};
//   JAL {11{i31},i31,i[19:12],i20,i[30:21],0}; LUI/AUIPC {i[31:12],12'h0}; else 0.
//  Illegal=1 when: inst[1:0]!=11; opcode not in the 11 classes; R-type funct7 not 0000000, not 0100000 with
//   funct3 in {000,101}, and not (0000001 & ENABLE_M); I-type shift (001/101) with inst[31:25] not 0000000 or
//   (0100000 & funct3=101); branch funct3 010/011; load funct3 011/110/111; store funct3>=011; jalr funct3!=000.
//   When illegal: alu_op=0, opcode_vec=0, imm=0; pc/regs/funct3 still captured; out_valid=1 (execute traps).
//  Reset asserted mid-operation clears the slot immediately (async); the in-flight instruction is lost.
// TESTING
//  Reset: rst_n=0 -> out_valid=0, alu_op=0, opcode_vec=0, imm=0, illegal=0, in_ready=1.
//  inst=0x00A30293 (addi x5,x6,10), out_ready=1 -> next cycle alu_op[0]=1, opcode_vec[1]=1, imm=10, rd=5, rs1=6.
//  inst=0x403100B3 (sub) then 0xFE000EE3 (beq -4) back-to-back -> sub=1 then eq=1, imm=0xFFFFFFFC, no bubble.
//  Stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; release -> next inst loads.
//  Flush with in_valid=1 and full slot -> out_valid=0 next cycle, incoming inst discarded.
//  inst=0x023100B3 (mul): ENABLE_M=1 -> alu_op[14]=1, illegal=0; ENABLE_M=0 -> illegal=1, alu_op=0.

Source files
------------

// File: rtl/rv32_decode_stage.sv
// RV32I(+M) decode stage: one registered slot between fetch and execute.
// Ports: clk/rst_n, in_valid/in_ready/inst/pc_in from fetch, flush,
//   rs1_addr_d/rs2_addr_d (comb), out_valid/out_ready plus registered
//   pc_out, rs1/rs2/rd_addr, funct3, imm, alu_op, opcode_vec, illegal.
module rv32_decode_stage #(
  parameter int PC_WIDTH = 32,
  parameter bit ENABLE_M = 1'b0,
  localparam int ALU_W = ENABLE_M ? 22 : 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         inst,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic                flush,
  output logic [4:0]          rs1_addr_d,
  output logic [4:0]          rs2_addr_d,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [4:0]          rs1_addr,
  output logic [4:0]          rs2_addr,
  output logic [4:0]          rd_addr,
  output logic [2:0]          funct3,
  output logic [31:0]         imm,
  output logic [ALU_W-1:0]    alu_op,
  output logic [10:0]         opcode_vec,
  output logic                illegal
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_FEN = 7'b0001111;

  localparam int A_ADD  = 0;
  localparam int A_SUB  = 1;
  localparam int A_SLT  = 2;
  localparam int A_SLTU = 3;
  localparam int A_XOR  = 4;
  localparam int A_OR   = 5;
  localparam int A_AND  = 6;
  localparam int A_SLL  = 7;
  localparam int A_SRL  = 8;
  localparam int A_SRA  = 9;
  localparam int A_EQ   = 10;
  localparam int A_NEQ  = 11;
  localparam int A_GE   = 12;
  localparam int A_GEU  = 13;
  localparam int A_MUL  = 14;

  function automatic logic [ALU_W-1:0] onehot(input int k);
    onehot = ALU_W'(1) << k;
  endfunction

  // Shared R/I arithmetic mapping; alt selects sub/sra.
  function automatic logic [ALU_W-1:0] arith(
    input logic [2:0] f,
    input logic       alt
  );
    unique case (f)
      3'b000:  arith = onehot(alt ? A_SUB : A_ADD);
      3'b001:  arith = onehot(A_SLL);
      3'b010:  arith = onehot(A_SLT);
      3'b011:  arith = onehot(A_SLTU);
      3'b100:  arith = onehot(A_XOR);
      3'b101:  arith = onehot(alt ? A_SRA : A_SRL);
      3'b110:  arith = onehot(A_OR);
      default: arith = onehot(A_AND);
    endcase
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  assign rs1_addr_d = inst[19:15];
  assign rs2_addr_d = inst[24:20];

  logic [ALU_W-1:0] alu_dec;
  logic [10:0]      opv_dec;
  logic [31:0]      imm_dec;
  logic             bad;

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};
  assign imm_u = {inst[31:12], 12'h000};

  always_comb begin
    alu_dec = onehot(A_ADD);
    opv_dec = '0;
    imm_dec = '0;
    bad     = 1'b0;
    unique case (opc)
      OP_R: begin
        opv_dec[0] = 1'b1;
        if (f7 == 7'h00)
          alu_dec = arith(f3, 1'b0);
        else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))
          alu_dec = arith(f3, 1'b1);
        else if (f7 == 7'h01 && ENABLE_M)
          alu_dec = onehot(A_MUL + int'(f3));
        else
          bad = 1'b1;
      end
      OP_I: begin
        opv_dec[1] = 1'b1;
        imm_dec    = imm_i;
        alu_dec    = arith(f3, f3 == 3'b101 && inst[30]);
        if (f3 == 3'b001 && f7 != 7'h00)
          bad = 1'b1;
        if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)
          bad = 1'b1;
      end
      OP_LD: begin
        opv_dec[2] = 1'b1;
        imm_dec    = imm_i;
        bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OP_ST: begin
        opv_dec[3] = 1'b1;
        imm_dec    = imm_s;
        bad = (f3 >= 3'b011);
      end
      OP_BR: begin
        opv_dec[4] = 1'b1;
        imm_dec    = imm_b;
        unique case (f3)
          3'b000:  alu_dec = onehot(A_EQ);
          3'b001:  alu_dec = onehot(A_NEQ);
          3'b100:  alu_dec = onehot(A_SLT);
          3'b101:  alu_dec = onehot(A_GE);
          3'b110:  alu_dec = onehot(A_SLTU);
          3'b111:  alu_dec = onehot(A_GEU);
          default: bad = 1'b1;
        endcase
      end
      OP_JAL: begin
        opv_dec[5] = 1'b1;
        imm_dec    = imm_j;
      end
      OP_JR: begin
        opv_dec[6] = 1'b1;
        imm_dec    = imm_i;
        bad = (f3 != 3'b000);
      end
      OP_LUI: begin
        opv_dec[7] = 1'b1;
        imm_dec    = imm_u;
      end
      OP_AUI: begin
        opv_dec[8] = 1'b1;
        imm_dec    = imm_u;
      end
      OP_SYS: opv_dec[9] = 1'b1;
      OP_FEN: opv_dec[10] = 1'b1;
      default: bad = 1'b1;
    endcase
  end

  logic                valid_q, valid_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [4:0]          rs1_q, rs1_d;
  logic [4:0]          rs2_q, rs2_d;
  logic [4:0]          rd_q, rd_d;
  logic [2:0]          f3_q, f3_d;
  logic [31:0]         imm_q, imm_d;
  logic [ALU_W-1:0]    alu_q, alu_d;
  logic [10:0]         opv_q, opv_d;
  logic                ill_q, ill_d;
  logic                load;

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    imm_d   = imm_q;
    alu_d   = alu_q;
    opv_d   = opv_q;
    ill_d   = ill_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = pc_in;
      rs1_d   = inst[19:15];
      rs2_d   = inst[24:20];
      rd_d    = inst[11:7];
      f3_d    = f3;
      // Illegal beats still occupy the slot so execute can trap.
      imm_d   = bad ? '0 : imm_dec;
      alu_d   = bad ? '0 : alu_dec;
      opv_d   = bad ? '0 : opv_dec;
      ill_d   = bad;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      opv_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      opv_q   <= opv_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid  = valid_q;
  assign pc_out     = pc_q;
  assign rs1_addr   = rs1_q;
  assign rs2_addr   = rs2_q;
  assign rd_addr    = rd_q;
  assign funct3     = f3_q;
  assign imm        = imm_q;
  assign alu_op     = alu_q;
  assign opcode_vec = opv_q;
  assign illegal    = ill_q;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: M-less and M-enabled copies side by side,
// checked each cycle against a behavioural slot model plus literals.
module tb_rv32_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] inst;
  logic [31:0] pc_in;
  logic        flush;
  logic        out_ready;

  logic        rdy0, vld0, ill0;
  logic [4:0]  a1d0, a2d0, rs10, rs20, rd0;
  logic [2:0]  f30;
  logic [31:0] pc0, imm0;
  logic [13:0] alu0;
  logic [10:0] opv0;

  logic        rdy1, vld1, ill1;
  logic [4:0]  a1d1, a2d1, rs11, rs21, rd1;
  logic [2:0]  f31;
  logic [31:0] pc1, imm1;
  logic [21:0] alu1;
  logic [10:0] opv1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32_decode_stage #(.PC_WIDTH(32), .ENABLE_M(1'b0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .inst(inst), .pc_in(pc_in), .flush(flush),
    .rs1_addr_d(a1d0), .rs2_addr_d(a2d0),
    .out_valid(vld0), .out_ready(out_ready), .pc_out(pc0),
    .rs1_addr(rs10), .rs2_addr(rs20), .rd_addr(rd0),
    .funct3(f30), .imm(imm0), .alu_op(alu0),
    .opcode_vec(opv0), .illegal(ill0)
  );

  rv32_decode_stage #(.PC_WIDTH(32), .ENABLE_M(1'b1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .inst(inst), .pc_in(pc_in), .flush(flush),
    .rs1_addr_d(a1d1), .rs2_addr_d(a2d1),
    .out_valid(vld1), .out_ready(out_ready), .pc_out(pc1),
    .rs1_addr(rs11), .rs2_addr(rs21), .rd_addr(rd1),
    .funct3(f31), .imm(imm1), .alu_op(alu1),
    .opcode_vec(opv1), .illegal(ill1)
  );

  typedef struct packed {
    logic [21:0] alu;
    logic [10:0] opc;
    logic [31:0] imm;
    logic        ill;
  } dec_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    dec_t        d;
  } slot_t;

  slot_t ms0, ms1;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decoder: table lookups on the instruction fields.
  function automatic dec_t ref_decode(input logic [31:0] i, input bit m);
    int ar[8] = '{0, 7, 2, 3, 4, 8, 5, 6};
    int br[8] = '{10, 11, -1, -1, 2, 12, 3, 13};
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    logic signed [11:0] t12;
    logic signed [12:0] t13;
    logic signed [20:0] t21;
    logic signed [31:0] s;
    int cls = -1;
    int a = 0;
    bit ill = 0;
    dec_t r;
    s = 0;
    case (op)
      7'h33: cls = 0;
      7'h13: cls = 1;
      7'h03: cls = 2;
      7'h23: cls = 3;
      7'h63: cls = 4;
      7'h6F: cls = 5;
      7'h67: cls = 6;
      7'h37: cls = 7;
      7'h17: cls = 8;
      7'h73: cls = 9;
      7'h0F: cls = 10;
      default: cls = -1;
    endcase
    if (cls < 0) ill = 1;
    if (cls == 0) begin
      if (f7 == 0) a = ar[f3];
      else if (f7 == 7'h20 && f3 == 0) a = 1;
      else if (f7 == 7'h20 && f3 == 5) a = 9;
      else if (f7 == 7'h01 && m) a = 14 + f3;
      else ill = 1;
    end
    if (cls == 1) begin
      a = ar[f3];
      if (f3 == 1 && f7 != 0) ill = 1;
      if (f3 == 5 && f7 == 7'h20) a = 9;
      else if (f3 == 5 && f7 != 0) ill = 1;
    end
    if (cls == 2 && (f3 == 3 || f3 == 6 || f3 == 7)) ill = 1;
    if (cls == 3 && f3 >= 3) ill = 1;
    if (cls == 4) begin
      a = br[f3];
      if (a < 0) ill = 1;
    end
    if (cls == 6 && f3 != 0) ill = 1;
    if (cls == 1 || cls == 2 || cls == 6) begin
      t12 = i[31:20]; s = t12;
    end else if (cls == 3) begin
      t12 = {i[31:25], i[11:7]}; s = t12;
    end else if (cls == 4) begin
      t13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; s = t13;
    end else if (cls == 5) begin
      t21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; s = t21;
    end else if (cls == 7 || cls == 8) begin
      s = {i[31:12], 12'h000};
    end
    r = '0;
    r.ill = ill;
    if (!ill) begin
      r.alu = 22'(1) << a;
      r.opc = 11'(1) << cls;
      r.imm = s;
    end
    return r;
  endfunction

  function automatic slot_t next_slot(input slot_t s, input bit m);
    slot_t n = s;
    if (flush) n.valid = 0;
    else if (in_valid && (!s.valid || out_ready)) begin
      n.valid = 1;
      n.pc    = pc_in;
      n.rs1   = inst[19:15];
      n.rs2   = inst[24:20];
      n.rd    = inst[11:7];
      n.f3    = inst[14:12];
      n.d     = ref_decode(inst, m);
    end else if (out_ready) n.valid = 0;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms0 <= '0;
      ms1 <= '0;
    end else begin
      ms0 <= next_slot(ms0, 1'b0);
      ms1 <= next_slot(ms1, 1'b1);
    end
  end

  always @(negedge clk) begin
    cmp("m0_valid", 32'(vld0), 32'(ms0.valid));
    cmp("m0_ready", 32'(rdy0), 32'(!ms0.valid || out_ready));
    cmp("m0_rs1d", 32'(a1d0), 32'(inst[19:15]));
    cmp("m0_rs2d", 32'(a2d0), 32'(inst[24:20]));
    cmp("m0_pc", pc0, ms0.pc);
    cmp("m0_regs", {17'd0, rs10, rs20, rd0}, {17'd0, ms0.rs1, ms0.rs2, ms0.rd});
    cmp("m0_f3", 32'(f30), 32'(ms0.f3));
    cmp("m0_imm", imm0, ms0.d.imm);
    cmp("m0_alu", 32'(alu0), 32'(ms0.d.alu));
    cmp("m0_opc", 32'(opv0), 32'(ms0.d.opc));
    cmp("m0_ill", 32'(ill0), 32'(ms0.d.ill));
    cmp("m1_valid", 32'(vld1), 32'(ms1.valid));
    cmp("m1_ready", 32'(rdy1), 32'(!ms1.valid || out_ready));
    cmp("m1_pc", pc1, ms1.pc);
    cmp("m1_regs", {17'd0, rs11, rs21, rd1}, {17'd0, ms1.rs1, ms1.rs2, ms1.rd});
    cmp("m1_f3", 32'(f31), 32'(ms1.f3));
    cmp("m1_imm", imm1, ms1.d.imm);
    cmp("m1_alu", 32'(alu1), 32'(ms1.d.alu));
    cmp("m1_opc", 32'(opv1), 32'(ms1.d.opc));
    cmp("m1_ill", 32'(ill1), 32'(ms1.d.ill));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops[11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                            7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 12);
    int f = $urandom_range(0, 4);
    if (k < 11) r[6:0] = ops[k];
    if (f == 0 || f == 4) r[31:25] = 7'h00;
    else if (f == 1) r[31:25] = 7'h20;
    else if (f == 2) r[31:25] = 7'h01;
    return r;
  endfunction

  dec_t pin;

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    flush = 1'b0;
    inst = 32'h0;
    pc_in = 32'h0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    cmp("rst_valid", 32'(vld1), 32'd0);
    cmp("rst_alu", 32'(alu1), 32'd0);
    cmp("rst_opc", 32'(opv1), 32'd0);
    cmp("rst_imm", imm1, 32'd0);
    cmp("rst_ill", 32'(ill1), 32'd0);
    cmp("rst_ready", 32'(rdy1), 32'd1);
    rst_n = 1'b1;

    pin = ref_decode(32'h00A30293, 1'b0);
    cmp("pin_addi_alu", 32'(pin.alu), 32'd1);
    cmp("pin_addi_imm", pin.imm, 32'd10);
    pin = ref_decode(32'hFE000EE3, 1'b0);
    cmp("pin_beq_imm", pin.imm, 32'hFFFFFFFC);
    pin = ref_decode(32'h023100B3, 1'b1);
    cmp("pin_mul_alu", 32'(pin.alu), 32'h4000);

    tick();
    in_valid = 1'b1;
    inst = 32'h00A30293;
    pc_in = 32'h100;
    tick();
    in_valid = 1'b0;
    cmp("addi_valid", 32'(vld0), 32'd1);
    cmp("addi_alu", 32'(alu0), 32'd1);
    cmp("addi_opc", 32'(opv0), 32'd2);
    cmp("addi_imm", imm0, 32'd10);
    cmp("addi_rd", 32'(rd0), 32'd5);
    cmp("addi_rs1", 32'(rs10), 32'd6);

    in_valid = 1'b1;
    inst = 32'h403100B3;
    pc_in = 32'h104;
    tick();
    cmp("sub_alu", 32'(alu1), 32'd2);
    cmp("sub_valid", 32'(vld1), 32'd1);
    inst = 32'hFE000EE3;
    pc_in = 32'h108;
    tick();
    in_valid = 1'b0;
    cmp("beq_valid", 32'(vld1), 32'd1);
    cmp("beq_alu", 32'(alu1), 32'h400);
    cmp("beq_opc", 32'(opv1), 32'h10);
    cmp("beq_imm", imm1, 32'hFFFFFFFC);
    cmp("beq_pc", pc1, 32'h108);
    tick();

    out_ready = 1'b0;
    in_valid = 1'b1;
    inst = 32'h00500113;
    tick();
    cmp("stall_load_imm", imm0, 32'd5);
    inst = 32'h00700193;
    for (int c = 0; c < 3; c++) begin
      tick();
      cmp("stall_ready", 32'(rdy0), 32'd0);
      cmp("stall_imm", imm0, 32'd5);
      cmp("stall_valid", 32'(vld0), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    cmp("release_imm", imm0, 32'd7);
    cmp("release_rd", 32'(rd0), 32'd3);

    out_ready = 1'b0;
    inst = 32'h00900213;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cmp("flush_valid", 32'(vld0), 32'd0);
    cmp("flush_imm", imm0, 32'd7);

    in_valid = 1'b1;
    inst = 32'h023100B3;
    tick();
    in_valid = 1'b0;
    cmp("mul_m1_alu", 32'(alu1), 32'h4000);
    cmp("mul_m1_ill", 32'(ill1), 32'd0);
    cmp("mul_m0_ill", 32'(ill0), 32'd1);
    cmp("mul_m0_alu", 32'(alu0), 32'd0);
    cmp("mul_m0_valid", 32'(vld0), 32'd1);

    for (int n = 0; n < 3000; n++) begin
      tick();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      inst      = rand_inst();
      pc_in     = $urandom & 32'hFFFFFFFC;
      if (n == 1500) begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
    end
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
